gf180mcu_ocd_io__pwrseq: RTL

GF180MCU_OCD_IO__PWRSEQ -- requirements
Module: gf180mcu_ocd_io__pwrseq

---
 rtl/gf180mcu_ocd_io__pwrseq.sv | 223 ++++++++++++++++++++++
 1 files changed

// File: rtl/gf180mcu_ocd_io__pwrseq.sv
// Multi-domain supply sequencer: ramps domains up in index order, waits for
// power-good plus a settle delay, and powers down highest domain first.
// Optional compile-time feature: PWRSEQ_BROWNOUT_EN (brownout detection while ON).
module gf180mcu_ocd_io__pwrseq #(
  parameter int N_DOM = 4,
  parameter int DLY_W = 8,
  parameter int TMO   = 255
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             EN,
  input  logic [N_DOM-1:0] PG,
  input  logic [DLY_W-1:0] DLY,
  output logic [N_DOM-1:0] PWR_EN,
  output logic             RDY,
  output logic             FAULT,
  output logic [2:0]       FAULT_DOM,
  output logic [2:0]       o_dbg_state
);

  typedef enum logic [2:0] {
    S_OFF    = 3'd0,
    S_RAMP   = 3'd1,
    S_SETTLE = 3'd2,
    S_ON     = 3'd3,
    S_DOWN   = 3'd4,
    S_FLT    = 3'd5
  } state_t;

  localparam logic [2:0]  LAST_IDX = 3'(N_DOM - 1);
  localparam logic [15:0] TMO_LAST = 16'(TMO - 1);

  state_t             r_state;
  logic [2:0]         r_idx;
  logic [N_DOM-1:0]   r_pwr_en;
  logic               r_rdy;
  logic               r_fault;
  logic [2:0]         r_fault_dom;
  logic [15:0]        r_tmo_cnt;
  logic [DLY_W-1:0]   r_dly_cnt;

  state_t             w_state_nxt;
  logic [2:0]         w_idx_nxt;
  logic [N_DOM-1:0]   w_pwr_en_nxt;
  logic               w_rdy_nxt;
  logic               w_fault_nxt;
  logic [2:0]         w_fault_dom_nxt;
  logic [15:0]        w_tmo_cnt_nxt;
  logic [DLY_W-1:0]   w_dly_cnt_nxt;

  logic [N_DOM-1:0]   w_idx_mask;
  logic               w_pg_cur;
  logic               w_tmo_hit;
  logic               w_bo_trip;
  logic [2:0]         w_bo_dom;

  assign w_idx_mask = N_DOM'(1) << r_idx;
  assign w_pg_cur   = |(PG & w_idx_mask);
  assign w_tmo_hit  = !w_pg_cur && (r_tmo_cnt == TMO_LAST);

`ifdef PWRSEQ_BROWNOUT_EN
  // Per-domain run length of low power-good samples, only counted while ON.
  logic [1:0] r_bo_cnt [N_DOM];

  always_ff @(posedge CLK) begin
    for (int i = 0; i < N_DOM; i++) begin
      if (RST || r_state != S_ON || PG[i]) begin
        r_bo_cnt[i] <= 2'd0;
      end else if (r_bo_cnt[i] != 2'd3) begin
        r_bo_cnt[i] <= r_bo_cnt[i] + 2'd1;
      end
    end
  end

  // Descending scan so the lowest tripping domain wins.
  always_comb begin
    w_bo_trip = 1'b0;
    w_bo_dom  = 3'd0;
    for (int i = N_DOM - 1; i >= 0; i--) begin
      if (!PG[i] && r_bo_cnt[i] == 2'd3) begin
        w_bo_trip = 1'b1;
        w_bo_dom  = 3'(i);
      end
    end
  end
`else
  assign w_bo_trip = 1'b0;
  assign w_bo_dom  = 3'd0;
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state     <= S_OFF;
      r_idx       <= 3'd0;
      r_pwr_en    <= '0;
      r_rdy       <= 1'b0;
      r_fault     <= 1'b0;
      r_fault_dom <= 3'd0;
      r_tmo_cnt   <= 16'd0;
      r_dly_cnt   <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_idx       <= w_idx_nxt;
      r_pwr_en    <= w_pwr_en_nxt;
      r_rdy       <= w_rdy_nxt;
      r_fault     <= w_fault_nxt;
      r_fault_dom <= w_fault_dom_nxt;
      r_tmo_cnt   <= w_tmo_cnt_nxt;
      r_dly_cnt   <= w_dly_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_idx_nxt       = r_idx;
    w_pwr_en_nxt    = r_pwr_en;
    w_fault_nxt     = r_fault;
    w_fault_dom_nxt = r_fault_dom;
    w_tmo_cnt_nxt   = r_tmo_cnt;
    w_dly_cnt_nxt   = r_dly_cnt;

    case (r_state)
      S_OFF: begin
        if (EN) begin
          w_state_nxt   = S_RAMP;
          w_idx_nxt     = 3'd0;
          w_pwr_en_nxt  = N_DOM'(1);
          w_tmo_cnt_nxt = 16'd0;
        end
      end

      // Timeout outranks a falling EN in the same cycle.
      S_RAMP: begin
        if (w_tmo_hit) begin
          w_state_nxt     = S_FLT;
          w_pwr_en_nxt    = '0;
          w_fault_nxt     = 1'b1;
          w_fault_dom_nxt = r_idx;
          w_tmo_cnt_nxt   = 16'd0;
        end else if (!EN) begin
          w_state_nxt   = S_DOWN;
          w_dly_cnt_nxt = DLY;
          w_tmo_cnt_nxt = 16'd0;
        end else if (w_pg_cur) begin
          w_state_nxt   = S_SETTLE;
          w_dly_cnt_nxt = DLY;
          w_tmo_cnt_nxt = 16'd0;
        end else begin
          w_tmo_cnt_nxt = r_tmo_cnt + 16'd1;
        end
      end

      S_SETTLE: begin
        if (!EN) begin
          w_state_nxt   = S_DOWN;
          w_dly_cnt_nxt = DLY;
        end else if (r_dly_cnt == '0) begin
          if (r_idx == LAST_IDX) begin
            w_state_nxt = S_ON;
          end else begin
            w_state_nxt   = S_RAMP;
            w_idx_nxt     = r_idx + 3'd1;
            w_pwr_en_nxt  = r_pwr_en | (w_idx_mask << 1);
            w_tmo_cnt_nxt = 16'd0;
          end
        end else begin
          w_dly_cnt_nxt = r_dly_cnt - DLY_W'(1);
        end
      end

      S_ON: begin
        if (w_bo_trip) begin
          w_state_nxt     = S_FLT;
          w_pwr_en_nxt    = '0;
          w_fault_nxt     = 1'b1;
          w_fault_dom_nxt = w_bo_dom;
        end else if (!EN) begin
          w_state_nxt   = S_DOWN;
          w_dly_cnt_nxt = DLY;
        end
      end

      // Enables are thermometer-coded, so a right shift drops the highest bit.
      S_DOWN: begin
        if (r_dly_cnt != '0) begin
          w_dly_cnt_nxt = r_dly_cnt - DLY_W'(1);
        end else begin
          w_pwr_en_nxt  = r_pwr_en >> 1;
          w_dly_cnt_nxt = DLY;
          if (r_pwr_en == N_DOM'(1)) begin
            w_state_nxt   = S_OFF;
            w_idx_nxt     = 3'd0;
            w_dly_cnt_nxt = '0;
          end
        end
      end

      S_FLT: begin
        if (!EN) begin
          w_state_nxt = S_OFF;
          w_idx_nxt   = 3'd0;
          w_fault_nxt = 1'b0;
        end
      end

      default: begin
        w_state_nxt  = S_OFF;
        w_idx_nxt    = 3'd0;
        w_pwr_en_nxt = '0;
        w_fault_nxt  = 1'b0;
      end
    endcase

    w_rdy_nxt = (w_state_nxt == S_ON);
  end

  assign PWR_EN      = r_pwr_en;
  assign RDY         = r_rdy;
  assign FAULT       = r_fault;
  assign FAULT_DOM   = r_fault_dom;
  assign o_dbg_state = r_state;

endmodule
